// File: rtl/organ_pkg.sv
// Shared types and helpers for the keypad emulator: FSM state encoding,
// key-code slicing and default timing constants.
package organ_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BOUNCE_IN  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_BOUNCE_OUT = 3'd3,
    ST_GAP        = 3'd4
  } keyemu_state_t;

  typedef logic [3:0] key_code_t;

  localparam int DEF_GAP_CYCLES    = 16;
  localparam int DEF_BOUNCE_CYCLES = 64;
  localparam int DEF_BOUNCE_PERIOD = 8;

  function automatic logic [1:0] KEY_ROW(input key_code_t k);
    return k[3:2];
  endfunction

  function automatic logic [1:0] KEY_COL(input key_code_t k);
    return k[1:0];
  endfunction

  // Counter reload for HOLD: a requested hold of 0 behaves as 1 cycle.
  function automatic logic [15:0] hold_load(input logic [15:0] h);
    return (h == 16'd0) ? 16'd0 : h - 16'd1;
  endfunction

endpackage

// File: rtl/keypad_emu_bounce_gen.sv
// Contact chatter generator for bounce windows; only built when
// KEYPAD_EMU_BOUNCE_EN is defined.
`ifdef KEYPAD_EMU_BOUNCE_EN
module bounce_gen
  import organ_pkg::*;
#(
  parameter int BOUNCE_PERIOD = DEF_BOUNCE_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic enter,
  input  logic active,
  input  logic last,
  input  logic start_level,
  input  logic cur_level,
  output logic level_d
);

  localparam logic [15:0] PH_LOAD = 16'(BOUNCE_PERIOD - 1);

  logic [15:0] ph_q, ph_d;

  always_comb begin
    ph_d    = ph_q;
    level_d = cur_level;
    if (enter) begin
      ph_d    = PH_LOAD;
      level_d = start_level;
    end else if (active) begin
      if (ph_q == 16'd0) begin
        ph_d    = PH_LOAD;
        level_d = ~cur_level;
      end else begin
        ph_d = ph_q - 16'd1;
      end
    end
    // The final cycle of a window settles on the level the next state expects.
    if (active && last) level_d = start_level;
  end

  always_ff @(posedge clk) begin
    if (rst) ph_q <= 16'd0;
    else     ph_q <= ph_d;
  end

endmodule
`endif

// File: rtl/keypad_emu.sv
// Matrix keypad emulator: replays one key press per request onto a scanned
// 4x4 row/column interface. Optional contact bounce via KEYPAD_EMU_BOUNCE_EN.
module keypad_emu
  import organ_pkg::*;
#(
  parameter int CLK_HZ        = 27_000_000,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int BOUNCE_CYCLES = DEF_BOUNCE_CYCLES,
  parameter int BOUNCE_PERIOD = DEF_BOUNCE_PERIOD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  input  logic        req_valid,
  input  key_code_t   req_key,
  input  logic [15:0] req_hold,
  output logic        req_ready,
  output logic        busy,
  output logic        done,
  output logic        contact
);

  if (CLK_HZ < 1 || GAP_CYCLES < 1 || BOUNCE_CYCLES < 1 || BOUNCE_PERIOD < 1) begin : g_param_err
    $error("keypad_emu: GAP_CYCLES, BOUNCE_CYCLES and BOUNCE_PERIOD must be >= 1");
  end

  localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);

  keyemu_state_t state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  key_code_t     key_q, key_d;
  logic [15:0]   hold_q, hold_d;
  logic          contact_q, contact_d;
  logic          done_q, done_d;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != 16'd0) ? cnt_q - 16'd1 : 16'd0;
    key_d   = key_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 16'd0;
        if (req_valid) begin
          key_d  = req_key;
          hold_d = req_hold;
`ifdef KEYPAD_EMU_BOUNCE_EN
          state_d = ST_BOUNCE_IN;
          cnt_d   = 16'(BOUNCE_CYCLES - 1);
`else
          state_d = ST_HOLD;
          cnt_d   = hold_load(req_hold);
`endif
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      ST_BOUNCE_IN: if (cnt_q == 16'd0) begin
        state_d = ST_HOLD;
        cnt_d   = hold_load(hold_q);
      end
      ST_HOLD: if (cnt_q == 16'd0) begin
        state_d = ST_BOUNCE_OUT;
        cnt_d   = 16'(BOUNCE_CYCLES - 1);
      end
      ST_BOUNCE_OUT: if (cnt_q == 16'd0) begin
        state_d = ST_GAP;
        cnt_d   = GAP_LOAD;
      end
`else
      ST_HOLD: if (cnt_q == 16'd0) begin
        state_d = ST_GAP;
        cnt_d   = GAP_LOAD;
      end
`endif
      ST_GAP: if (cnt_q == 16'd0) begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

`ifdef KEYPAD_EMU_BOUNCE_EN
  logic bounce_active, bounce_level;
  assign bounce_active = (state_d == ST_BOUNCE_IN) || (state_d == ST_BOUNCE_OUT);

  bounce_gen #(.BOUNCE_PERIOD(BOUNCE_PERIOD)) u_bounce_gen (
    .clk         (clk),
    .rst         (rst),
    .enter       (bounce_active && (state_d != state_q)),
    .active      (bounce_active),
    .last        (cnt_d == 16'd0),
    .start_level (state_d == ST_BOUNCE_IN),
    .cur_level   (contact_q),
    .level_d     (bounce_level)
  );
`endif

  // Contact follows the next state so it is already valid on state entry.
  always_comb begin
    contact_d = 1'b0;
    case (state_d)
      ST_HOLD: contact_d = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
      ST_BOUNCE_IN, ST_BOUNCE_OUT: contact_d = bounce_level;
`endif
      default: contact_d = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      key_q     <= '0;
      hold_q    <= 16'd0;
      contact_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      hold_q    <= hold_d;
      contact_q <= contact_d;
      done_q    <= done_d;
    end
  end

  // Row sense answers a column change in the same cycle.
  always_comb begin
    row = 4'hF;
    if (contact_q && !col[KEY_COL(key_q)]) row[KEY_ROW(key_q)] = 1'b0;
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign contact   = contact_q;

endmodule
